// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, round count, rcon lookup and RotWord helper
// Contents:
//   AES_NUM_ROUNDS  number of AES-128 rounds (10)
//   state_t         128-bit column-major state / round key, byte 0 at [127:120]
//   word_t          32-bit key-schedule word
//   rcon()          round constant for round index 1..10 (0 elsewhere)
//   rot_word()      cyclic left rotation of a word by one byte
package aes_pkg;

  localparam int AES_NUM_ROUNDS = 10;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_addroundkey_sched_if.sv
// rtl/aes_addroundkey_sched_if.sv - state-beat stream bundle for the AddRoundKey stage
// Signals:
//   in_valid/in_ready/in_state                    upstream beat handshake
//   out_valid/out_ready/out_state/out_round/out_last  downstream beat handshake
// Modports:
//   slave   the AddRoundKey stage (consumes in_*, produces out_*)
//   master  the surrounding datapath or bench (produces in_*, consumes out_*)
interface aes_addroundkey_sched_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  state_t     in_state;
  logic       out_valid;
  logic       out_ready;
  state_t     out_state;
  logic [3:0] out_round;
  logic       out_last;

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state, out_round, out_last
  );

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state, out_round, out_last
  );

endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box, one byte
// Ports:
//   in_byte   8-bit input byte
//   out_byte  8-bit substituted byte
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry 0x00 sits in the top byte, so entry n starts at bit 8*(255-n).
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // 8*(255-n) == {~n, 3'b000}
  assign out_byte = SBOX[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_addroundkey_sched.sv
// rtl/aes_addroundkey_sched.sv - AddRoundKey stage with on-the-fly AES-128 key schedule
// Parameters:
//   NUM_ROUNDS  round at which out_last is raised and the schedule wraps (1..10)
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   key_load  one-cycle strobe capturing key_in as the round-0 key
//   key_in    128-bit cipher key, column-major
//   bus       slave side of the in/out state-beat handshake
//   out_rkey  round key applied to the beat in out_state (only with AES_ARK_RKEY_OUT_EN)
// Build option:
//   AES_ARK_RKEY_OUT_EN  adds the registered out_rkey port
module aes_addroundkey_sched
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_load,
  input  state_t                  key_in,
  aes_addroundkey_sched_if.slave  bus
`ifdef AES_ARK_RKEY_OUT_EN
  ,
  output state_t                  out_rkey
`endif
);

  state_t     key0;
  state_t     rkey;
  logic [3:0] round;
  logic       key_valid;

  logic       out_valid_q;
  state_t     out_state_q;
  logic [3:0] out_round_q;
  logic       out_last_q;

  logic       in_ready_c;
  logic       accept;
  logic       is_last;
  logic [3:0] round_next;

  word_t      w0, w1, w2, w3;
  word_t      rot, sub, t;
  word_t      n0, n1, n2, n3;
  state_t     next_key;

  // Key expansion runs combinationally from rkey so the next round key is
  // ready in the same cycle the current one is consumed.
  assign {w0, w1, w2, w3} = rkey;
  assign rot              = rot_word(w3);

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (rot[8*i +: 8]),
      .out_byte (sub[8*i +: 8])
    );
  end

  assign round_next = round + 4'd1;
  assign t          = sub ^ {rcon(round_next), 24'h000000};
  assign n0         = w0 ^ t;
  assign n1         = w1 ^ n0;
  assign n2         = w2 ^ n1;
  assign n3         = w3 ^ n2;
  assign next_key   = {n0, n1, n2, n3};

  assign is_last    = (round == 4'(NUM_ROUNDS));

  // key_load blocks acceptance so a beat never straddles a key change.
  assign in_ready_c = key_valid & ~key_load & (~out_valid_q | bus.out_ready);
  assign accept     = bus.in_valid & in_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key0      <= '0;
      rkey      <= '0;
      round     <= '0;
      key_valid <= 1'b0;
    end else if (key_load) begin
      key0      <= key_in;
      rkey      <= key_in;
      round     <= '0;
      key_valid <= 1'b1;
    end else if (accept) begin
      if (is_last) begin
        rkey  <= key0;
        round <= '0;
      end else begin
        rkey  <= next_key;
        round <= round_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_state_q <= '0;
      out_round_q <= '0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_state_q <= bus.in_state ^ rkey;
      out_round_q <= round;
      out_last_q  <= is_last;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef AES_ARK_RKEY_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_rkey <= '0;
    end else if (accept) begin
      out_rkey <= rkey;
    end
  end
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = out_state_q;
  assign bus.out_round = out_round_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_aes_addroundkey_sched.sv
// tb/tb_aes_addroundkey_sched.sv - scoreboard bench for aes_addroundkey_sched
module tb_aes_addroundkey_sched;
  import aes_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   key_load = 1'b0;
  state_t key_in = '0;

  aes_addroundkey_sched_if bus ();

`ifdef AES_ARK_RKEY_OUT_EN
  state_t out_rkey;
`endif

  aes_addroundkey_sched #(.NUM_ROUNDS(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_load (key_load),
    .key_in   (key_in),
    .bus      (bus.slave)
`ifdef AES_ARK_RKEY_OUT_EN
    ,
    .out_rkey (out_rkey)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    state_t     st;
    state_t     rk;
    logic [3:0] rnd;
    logic       last;
  } exp_t;

  exp_t   sb[$];
  int     n_cmp = 0;
  int     n_fail = 0;

  state_t ka [0:10];
  state_t kz [0:2];
  int     m_round = 0;
  bit     m_zero = 1'b0;
  state_t last_exp;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic state_t cur_key();
    return m_zero ? kz[m_round] : ka[m_round];
  endfunction

  task automatic push_exp(input state_t d);
    exp_t e;
    e.rk     = cur_key();
    e.st     = d ^ e.rk;
    e.rnd    = 4'(m_round);
    e.last   = (m_round == 10);
    last_exp = e.st;
    sb.push_back(e);
    m_round  = (m_round == 10) ? 0 : m_round + 1;
  endtask

  // Leaves in_valid asserted so consecutive calls stream back-to-back.
  task automatic send_beat(input state_t d, output int waits);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_state = d;
    waits = 0;
    while (!done && waits < 50) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push_exp(d);
        done = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: beat %h not accepted within 50 cycles", d);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_key(input state_t k, input bit zero);
    @(posedge clk);
    #1;
    key_in   = k;
    key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    m_zero   = zero;
    m_round  = 0;
  endtask

  // Monitor: a beat transfers at the next rising edge whenever it is seen
  // valid and ready on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h expected none", bus.out_state);
        end else begin
          e = sb.pop_front();
          chk("out_state", bus.out_state, e.st);
          chk("out_round", 128'(bus.out_round), 128'(e.rnd));
          chk("out_last", 128'(bus.out_last), 128'(e.last));
`ifdef AES_ARK_RKEY_OUT_EN
          chk("out_rkey", out_rkey, e.rk);
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     w;
    state_t hold;

    ka[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ka[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    ka[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    ka[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    ka[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    ka[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    ka[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    ka[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    ka[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    ka[9]  = 128'hac7766f319fadc2128d12941575c006e;
    ka[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    kz[0]  = 128'h00000000000000000000000000000000;
    kz[1]  = 128'h62636363626363636263636362636363;
    kz[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_state", bus.out_state, 128'd0);
    chk("rst_out_round", 128'(bus.out_round), 128'd0);
    chk("rst_out_last", 128'(bus.out_last), 128'd0);
`ifdef AES_ARK_RKEY_OUT_EN
    chk("rst_out_rkey", out_rkey, 128'd0);
`endif
    #20;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("nokey_in_ready", 128'(bus.in_ready), 128'd0);

    // Full schedule, wrap and back-to-back throughput
    load_key(ka[0], 1'b0);
    for (int i = 0; i < 12; i++) begin
      send_beat('0, w);
      chk("no_bubble", 128'(w), 128'd0);
    end

    // Non-zero data, rounds 1..3
    send_beat(128'hffffffffffffffffffffffffffffffff, w);
    send_beat(128'h00112233445566778899aabbccddeeff, w);
    send_beat(128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0, w);

    // Backpressure while the round-3 beat is held
    bus.out_ready = 1'b0;
    hold = last_exp;
    fork
      send_beat(128'h3243f6a8885a308d313198a2e0370734, w);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
          chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
          chk("bp_hold", bus.out_state, hold);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join

    // key_load after round 4; blocks acceptance in its own cycle
    key_in       = kz[0];
    key_load     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_state = 128'h0123456789abcdeffedcba9876543210;
    @(negedge clk);
    chk("keyload_in_ready", 128'(bus.in_ready), 128'd0);
    @(posedge clk);
    #1;
    key_load = 1'b0;
    m_zero   = 1'b1;
    m_round  = 0;
    send_beat(128'h0123456789abcdeffedcba9876543210, w);
    send_beat(128'h00000000000000000000000000000000, w);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with a beat held in the output register
    bus.out_ready = 1'b0;
    send_beat(128'hdeadbeefdeadbeefdeadbeefdeadbeef, w);
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 128'(bus.out_valid), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("arst_in_ready", 128'(bus.in_ready), 128'd0);
    chk("arst_out_state", bus.out_state, 128'd0);
    sb.delete();
    m_round = 0;
    #10;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_in_ready", 128'(bus.in_ready), 128'd0);
    end
    bus.in_valid = 1'b0;

    load_key(ka[0], 1'b0);
    send_beat(128'h11111111222222223333333344444444, w);
    send_beat(128'h00000000000000000000000000000000, w);
    bus.in_valid = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 128'(sb.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_addroundkey_sched.md
# aes_addroundkey_sched

AddRoundKey stage with an on-the-fly AES-128 key schedule. It accepts state beats from MixColumns (or from ShiftRows on the final round) over a valid/ready handshake. Each beat is XORed with the current round key into a registered output. The round key is then advanced in place, so no 11-entry key table is stored. The block sits directly downstream of aes_mixcolumns in the iterative round datapath.

## Interface
- NUM_ROUNDS, 10: round index at which out_last is raised and the schedule wraps to round 0. Legal range is 1..10.
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- key_load  in  1  one-cycle strobe; captures key_in as round-0 key
- key_in  in  128  cipher key; byte 0 at [127:120], column-major, same layout as the MixColumns state
- in_valid  in  1  in_state is valid
- in_ready  out  1  stage can accept a beat this cycle
- in_state  in  128  state from the previous stage, column-major
- out_valid  out  1  out_state is valid
- out_ready  in  1  downstream accepts out_state
- out_state  out  128  in_state XOR round key
- out_round  out  4  round index (0..NUM_ROUNDS) used for out_state
- out_last  out  1  out_round == NUM_ROUNDS

## Operation
- Registers:
  - key0: stored cipher key
  - rkey: current round key
  - round: 4-bit round counter
  - key_valid
  - output register (out_state, out_round, out_last, out_valid)
- Handshake:
  - in_ready = key_valid & !key_load & (!out_valid | out_ready).
  - A beat is accepted when in_valid & in_ready.
- On accept:
  - out_state <= in_state ^ rkey; out_round <= round; out_last <= (round == NUM_ROUNDS); out_valid <= 1.
  - If round == NUM_ROUNDS: rkey <= key0 and round <= 0 (wrap for the next block).
  - Else: rkey <= next_key(rkey, round+1) and round <= round+1.
- next_key(w0..w3, r), where w0 = [127:96]:
  - t = SubWord(RotWord(w3)) ^ {rcon[r], 24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- out_valid clears when out_ready & out_valid and no new accept occurs in that cycle.
- key_load:
  - key0 <= key_in; rkey <= key_in; round <= 0; key_valid <= 1.
  - key_load has priority: in_ready is forced low that cycle, so no beat is accepted.
  - A beat already in the output register is unaffected and drains normally.
- Before the first key_load: key_valid = 0 and in_ready = 0.

## Timing
- Reset values:
  - in_ready 0, out_valid 0, out_state 0, out_round 0, out_last 0.
  - key0 0, rkey 0, round 0, key_valid 0.
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1 beat/cycle while out_ready = 1.
- Backpressure:
  - out_ready = 0 with out_valid = 1 drives in_ready low.
  - out_state, out_round and out_last must then hold stable.
- Key expansion is combinational from rkey within the accept cycle. No extra stall cycles.
- Reset mid-block: all registers return to reset values immediately. A new key_load is required before any further beat is accepted.
- key_load mid-block (round ≠ 0): the partial block is abandoned and the next accepted beat uses round 0.
- Back-to-back wrap: the beat after an out_last beat uses key0 with no bubble.

## Configuration
- AES_ARK_RKEY_OUT_EN
  - Defined: adds output port out_rkey [127:0], registered with out_state. It holds the round key applied to that beat and resets to 0.
  - Undefined: the port and its 128 flops are absent; all other behaviour is identical.

## Structure
- Shared package aes_pkg holds:
  - AES_NUM_ROUNDS = 10.
  - rcon lookup function (index 1..10).
  - 128-bit state/word typedefs.
  - rot_word helper.
- One sub-module: aes_sbox (combinational 8-bit S-box). It is instantiated 4× for SubWord and is reused by the SubBytes stage.

## Test plan
- Basic key and round 0:
  - Stimulus: reset, then key_load with key 2b7e151628aed2a6abf7158809cf4f3c, then an all-zero beat.
  - Response: out_state = 2b7e151628aed2a6abf7158809cf4f3c, out_round = 0, out_last = 0.
- Round 1 key: a second zero beat gives out_state = a0fafe1788542cb123a339392a6c7605 with out_round = 1.
- Full schedule and wrap:
  - Stimulus: 11 consecutive zero beats.
  - Response: beat 11 gives d014f9a8c9ee2589e13f0cc8b6630ca6 with out_round = 10 and out_last = 1.
  - The 12th beat again gives the round-0 key, with no idle cycle.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 5 cycles with in_valid = 1.
  - Response: in_ready = 0, out_state stable, no beat lost. The round sequence resumes correctly after release.
- key_load mid-block: key_load after round 4 → the next beat uses the new key at round 0, and no beat is accepted during the key_load cycle.
- Reset mid-operation:
  - Stimulus: assert rst_n low while out_valid = 1.
  - Response: out_valid and in_ready go to 0 asynchronously, and in_ready stays 0 until key_load.
